cv32e40x_xif_aes_ctrl: RTL

CV32E40X_XIF_AES_CTRL -- requirements
Module: cv32e40x_xif_aes_ctrl

---
 rtl/cv32e40x_xif_aes_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40x_xif_aes_ctrl.sv
// rtl/cv32e40x_xif_aes_ctrl.sv - XIF offload controller for the RV32 AES (Zkne/Zknd) functional unit
//
// Accepts AES32{ES,ESM,DS,DSM}I instructions over the XIF issue interface,
// queues them in a small in-order buffer, waits for the core's commit/kill
// decision, drives a single-cycle-handshake AES FU and returns the result
// over the XIF result interface.
//
// Ports:
//   clk_i, rst_n                 clock, asynchronous active-low reset
//   issue_*                      XIF issue request/response
//   commit_*                     XIF commit (commit or kill by instruction ID)
//   fu_valid_o/fu_ready_i        AES FU handshake; fu_rs1/rs2/bs/op drive, fu_rd_i result
//   result_*                     XIF result (id, data, destination register)

module cv32e40x_xif_aes_ctrl #(
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [1:0]            issue_rs_valid_i,
  input  logic [31:0]           issue_rs0_i,
  input  logic [31:0]           issue_rs1_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  fu_valid_o,
  output logic [31:0]           fu_rs1_o,
  output logic [31:0]           fu_rs2_o,
  output logic [1:0]            fu_bs_o,
  output logic [3:0]            fu_op_o,
  input  logic [31:0]           fu_rd_i,
  input  logic                  fu_ready_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o
);

  localparam logic [6:0] OPC_AES32 = 7'b0110011;
  localparam logic [4:0] F5_ESI    = 5'b10001;
  localparam logic [4:0] F5_ESMI   = 5'b10011;
  localparam logic [4:0] F5_DSI    = 5'b10101;
  localparam logic [4:0] F5_DSMI   = 5'b10111;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  logic [DEPTH-1:0]      ent_valid, ent_committed, ent_killed;
  logic [X_ID_WIDTH-1:0] ent_id  [DEPTH];
  logic [31:0]           ent_rs0 [DEPTH];
  logic [31:0]           ent_rs1 [DEPTH];
  logic [1:0]            ent_bs  [DEPTH];
  logic [4:0]            ent_rd  [DEPTH];
  logic [3:0]            ent_op  [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  state_t                state, state_nxt;
  logic [X_ID_WIDTH-1:0] res_id;
  logic [31:0]           res_data;
  logic [4:0]            res_rd;

  logic [3:0] dec_op;
  logic       decodable, push, pop, capture;
  logic       head_hit, head_kill, head_go;
  logic       unused_instr;

  // rs1/rs2/funct3 fields are carried by the operand values, not decoded here.
  assign unused_instr = ^issue_instr_i[24:12];

  always_comb begin
    dec_op = 4'b0000;
    case (issue_instr_i[29:25])
      F5_ESI:  dec_op = 4'b1000;
      F5_ESMI: dec_op = 4'b0100;
      F5_DSI:  dec_op = 4'b0010;
      F5_DSMI: dec_op = 4'b0001;
      default: dec_op = 4'b0000;
    endcase
  end

  assign decodable = (issue_instr_i[6:0] == OPC_AES32) && (dec_op != 4'b0000) &&
                     (issue_rs_valid_i == 2'b11);
  assign issue_ready_o = (count < CW'(DEPTH));
  // rst_n keeps the combinational accept low while reset is asserted.
  assign push = rst_n && issue_valid_i && issue_ready_o && decodable;
  assign issue_accept_o    = push;
  assign issue_writeback_o = push;

  // A commit arriving this cycle for the head counts immediately, so a
  // committed head starts executing in the cycle after the commit.
  assign head_hit  = commit_valid_i && ent_valid[head] && !ent_committed[head] &&
                     !ent_killed[head] && (commit_id_i == ent_id[head]);
  assign head_kill = ent_valid[head] && (ent_killed[head] || (head_hit && commit_kill_i));
  assign head_go   = ent_valid[head] && (ent_committed[head] || (head_hit && !commit_kill_i));

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    capture        = 1'b0;
    fu_valid_o     = 1'b0;
    fu_rs1_o       = '0;
    fu_rs2_o       = '0;
    fu_bs_o        = '0;
    fu_op_o        = '0;
    result_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (head_kill) begin
          pop = 1'b1;
        end else if (head_go) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        fu_valid_o = 1'b1;
        fu_rs1_o   = ent_rs0[head];
        fu_rs2_o   = ent_rs1[head];
        fu_bs_o    = ent_bs[head];
        fu_op_o    = ent_op[head];
        if (fu_ready_i) begin
          pop       = 1'b1;
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      res_id   <= '0;
      res_data <= '0;
      res_rd   <= '0;
    end else if (capture) begin
      res_id   <= ent_id[head];
      res_data <= fu_rd_i;
      res_rd   <= ent_rd[head];
    end
  end

  assign result_id_o   = res_id;
  assign result_data_o = res_data;
  assign result_rd_o   = res_rd;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      ent_valid     <= '0;
      ent_committed <= '0;
      ent_killed    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_id[i]  <= '0;
        ent_rs0[i] <= '0;
        ent_rs1[i] <= '0;
        ent_bs[i]  <= '0;
        ent_rd[i]  <= '0;
        ent_op[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && ent_valid[i] && !ent_committed[i] && !ent_killed[i] &&
            (commit_id_i == ent_id[i])) begin
          if (commit_kill_i) ent_killed[i] <= 1'b1;
          else               ent_committed[i] <= 1'b1;
        end
        if (pop && (PW'(i) == head)) begin
          ent_valid[i]     <= 1'b0;
          ent_committed[i] <= 1'b0;
          ent_killed[i]    <= 1'b0;
        end
        // Push never targets the popped slot: that needs count 0 or DEPTH.
        if (push && (PW'(i) == tail)) begin
          ent_valid[i]     <= 1'b1;
          ent_id[i]        <= issue_id_i;
          ent_rs0[i]       <= issue_rs0_i;
          ent_rs1[i]       <= issue_rs1_i;
          ent_bs[i]        <= issue_instr_i[31:30];
          ent_rd[i]        <= issue_instr_i[11:7];
          ent_op[i]        <= dec_op;
          ent_committed[i] <= commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
          ent_killed[i]    <= commit_valid_i && commit_kill_i && (commit_id_i == issue_id_i);
        end
      end
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
